// File: rtl/peg_input_encoder.sv
// Player-side peg-entry encoder: debounces the confirm/undo keys into a 00/01/10
// code stream, latches the peg colour, and tracks turn, win and game-over.
module peg_input_encoder #(
  parameter int DEBOUNCE  = 250000,
  parameter int CNT_W     = 18,
  parameter int MIN_GAP   = 4,
  parameter int MAX_TURNS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_confirm_n,
  input  logic       key_undo_n,
  input  logic [2:0] sw_color,
  input  logic [1:0] go,
  output logic [1:0] data,
  output logic [2:0] color_out,
  output logic [3:0] turn,
  output logic       won,
  output logic       game_over
);

  typedef enum logic [2:0] {WREL, IDLE, DEB, ACT, GAP} state_t;

  localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(MIN_GAP - 1);
  localparam logic [3:0]       LAST_TURN = 4'(MAX_TURNS - 1);
  localparam logic [1:0]       CODE_IDLE = 2'b00;
  localparam logic [1:0]       CODE_CONF = 2'b01;
  localparam logic [1:0]       CODE_UNDO = 2'b10;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       data_nxt;
  logic [2:0]       color_nxt;
  logic             sel_undo, sel_nxt;
  logic [1:0]       conf_sync, undo_sync;
  logic [1:0]       go_q;
  logic             conf_pressed, undo_pressed, any_pressed, sel_pressed;
  logic             turn_done;

  // Synchronizers park at "released" so reset never fabricates a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      conf_sync <= 2'b11;
      undo_sync <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments keep the flop chain a true two-stage shift.
      conf_sync <= {conf_sync[0], key_confirm_n};
      undo_sync <= {undo_sync[0], key_undo_n};
    end
  end

  assign conf_pressed = ~conf_sync[1];
  assign undo_pressed = ~undo_sync[1];
  assign any_pressed  = conf_pressed | undo_pressed;
  assign sel_pressed  = sel_undo ? undo_pressed : conf_pressed;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WREL;
      cnt       <= '0;
      data      <= CODE_IDLE;
      color_out <= 3'b000;
      sel_undo  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      data      <= data_nxt;
      color_out <= color_nxt;
      sel_undo  <= sel_nxt;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data;
    color_nxt = color_out;
    sel_nxt   = sel_undo;
    unique case (state)
      WREL: begin
        data_nxt = CODE_IDLE;
        if (any_pressed) begin
          cnt_nxt = '0;
        end else if (cnt == DEB_MAX) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      IDLE: begin
        data_nxt = CODE_IDLE;
        cnt_nxt  = '0;
        if (!game_over && any_pressed) begin
          state_nxt = DEB;
          cnt_nxt   = CNT_W'(1);
          sel_nxt   = ~conf_pressed;  // confirm wins a tie
        end
      end
      DEB: begin
        data_nxt = CODE_IDLE;
        if (!sel_pressed) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_MAX) begin
          state_nxt = ACT;
          cnt_nxt   = '0;
          data_nxt  = sel_undo ? CODE_UNDO : CODE_CONF;
          if (!sel_undo) color_nxt = sw_color;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ACT: begin
        if (sel_pressed) begin
          cnt_nxt = '0;
        end else if (cnt == DEB_MAX) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
          data_nxt  = CODE_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP: begin
        data_nxt = CODE_IDLE;
        if (cnt == GAP_LAST) begin
          state_nxt = any_pressed ? WREL : IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = WREL;
        cnt_nxt   = '0;
        data_nxt  = CODE_IDLE;
      end
    endcase
  end

  // A long go=01 pulse counts as a single turn completion.
  assign turn_done = (go == 2'b01) && (go_q != 2'b01);

  always_ff @(posedge clk) begin
    if (reset) begin
      go_q      <= 2'b00;
      turn      <= 4'd0;
      won       <= 1'b0;
      game_over <= 1'b0;
    end else begin
      go_q <= go;
      if (turn_done) begin
        if (turn < LAST_TURN) turn <= turn + 1'b1;
        else                  game_over <= 1'b1;
      end
      if (go == 2'b10) begin
        won       <= 1'b1;
        game_over <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_peg_input_encoder.sv
// Directed bench for peg_input_encoder with a short debounce window: code timing,
// bounce rejection, key priority, turn/win tracking and reset mid-press.
module tb_peg_input_encoder;

  localparam int D       = 8;
  localparam int MIN_GAP = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_confirm_n, key_undo_n;
  logic [2:0] sw_color;
  logic [1:0] go;
  logic [1:0] data;
  logic [2:0] color_out;
  logic [3:0] turn;
  logic       won, game_over;

  int n_checks = 0;
  int n_errors = 0;

  peg_input_encoder #(.DEBOUNCE(D), .CNT_W(4), .MIN_GAP(MIN_GAP), .MAX_TURNS(10)) dut (
    .clk(clk), .reset(reset), .key_confirm_n(key_confirm_n), .key_undo_n(key_undo_n),
    .sw_color(sw_color), .go(go), .data(data), .color_out(color_out),
    .turn(turn), .won(won), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] go;
    int         cycles;
    logic [3:0] exp_turn;
    logic       exp_won;
    logic       exp_gover;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Press keys and expect the code exactly 2 + D + 1 edges later.
  task automatic press_code(input logic c, input logic u, input logic [2:0] sw,
                            input logic [1:0] exp_code, input logic [2:0] exp_col,
                            input string name);
    key_confirm_n = ~c;
    key_undo_n    = ~u;
    sw_color      = sw;
    repeat (D + 2) tick();
    check({name, "_pre"}, 32'(data), 32'(2'b00));
    tick();
    check({name, "_code"}, 32'(data), 32'(exp_code));
    check({name, "_color"}, 32'(color_out), 32'(exp_col));
  endtask

  // Release all keys; code holds D+2 more edges, then 00 for the whole gap.
  task automatic release_code(input logic [1:0] exp_code, input string name);
    key_confirm_n = 1'b1;
    key_undo_n    = 1'b1;
    repeat (D + 2) tick();
    check({name, "_hold"}, 32'(data), 32'(exp_code));
    tick();
    check({name, "_gap_entry"}, 32'(data), 32'(2'b00));
    for (int i = 0; i < MIN_GAP; i++) begin
      tick();
      check({name, "_gap"}, 32'(data), 32'(2'b00));
    end
  endtask

  // Hold confirm for a long time and expect no code at all.
  task automatic expect_no_code(input int cycles, input string name);
    logic seen;
    seen = 1'b0;
    key_confirm_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      seen |= (data != 2'b00);
    end
    key_confirm_n = 1'b1;
    repeat (4) tick();
    check(name, 32'(seen), 32'd0);
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].rst) begin
        reset = 1'b1;
        repeat (vecs[i].cycles) tick();
        reset = 1'b0;
      end else begin
        go = vecs[i].go;
        repeat (vecs[i].cycles) tick();
        go = 2'b00;
      end
      check($sformatf("vec%0d_turn", i), 32'(turn), 32'(vecs[i].exp_turn));
      check($sformatf("vec%0d_won", i), 32'(won), 32'(vecs[i].exp_won));
      check($sformatf("vec%0d_gover", i), 32'(game_over), 32'(vecs[i].exp_gover));
      tick();
    end
  endtask

  initial begin
    logic seen;

    // Ten 3-cycle go pulses from turn 0; the tenth ends the game at turn 9.
    for (int i = 0; i < 10; i++)
      vecs[i] = '{1'b0, 2'b01, 3, (i < 9) ? 4'(i + 1) : 4'd9, 1'b0, (i == 9)};
    vecs[10] = '{1'b1, 2'b00, 2, 4'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 2'b01, 1, 4'd1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 2'b01, 1, 4'd2, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 2'b01, 1, 4'd3, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 2'b10, 1, 4'd3, 1'b1, 1'b1};

    reset = 1'b1; key_confirm_n = 1'b1; key_undo_n = 1'b1; sw_color = 3'b111; go = 2'b00;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_data", 32'(data), 32'd0);
    check("rst_color", 32'(color_out), 32'd0);
    check("rst_turn", 32'(turn), 32'd0);
    check("rst_won", 32'(won), 32'd0);
    check("rst_gover", 32'(game_over), 32'd0);
    repeat (D + 2) tick();

    // Basic confirm; colour must not follow the switches while the code is held.
    press_code(1'b1, 1'b0, 3'b101, 2'b01, 3'b101, "confirm");
    sw_color = 3'b010;
    repeat (2) tick();
    check("color_stable", 32'(color_out), 32'(3'b101));
    release_code(2'b01, "confirm");

    // Bounce shorter than the window, then a full press with unchanged latency.
    key_confirm_n = 1'b0;
    repeat (D - 1) tick();
    key_confirm_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < D + 6; i++) begin
      tick();
      seen |= (data != 2'b00);
    end
    check("bounce_no_code", 32'(seen), 32'd0);
    press_code(1'b1, 1'b0, 3'b110, 2'b01, 3'b110, "after_bounce");
    release_code(2'b01, "after_bounce");

    // Simultaneous press: confirm wins, undo activity during ACT is ignored.
    press_code(1'b1, 1'b1, 3'b001, 2'b01, 3'b001, "both");
    key_undo_n = 1'b1;
    repeat (3) tick();
    key_undo_n = 1'b0;
    repeat (3) tick();
    check("both_undo_ignored", 32'(data), 32'(2'b01));
    key_confirm_n = 1'b1;
    repeat (D + 2) tick();
    check("both_hold", 32'(data), 32'(2'b01));
    tick();
    check("both_gap", 32'(data), 32'(2'b00));
    seen = 1'b0;
    for (int i = 0; i < 3 * D; i++) begin
      if (i == MIN_GAP + 2) key_undo_n = 1'b1;
      tick();
      seen |= (data != 2'b00);
    end
    check("both_no_undo_code", 32'(seen), 32'd0);

    // Undo produces 10 and leaves the latched colour alone.
    press_code(1'b0, 1'b1, 3'b011, 2'b10, 3'b001, "undo");
    release_code(2'b10, "undo");

    // Turn tracking to the last row, then presses are ignored.
    apply_vecs(0, 9);
    expect_no_code(D + 8, "gover_press");

    // Fresh game: turn 3 then a win.
    apply_vecs(10, 14);
    expect_no_code(D + 8, "won_press");

    // Reset while a confirm code is being held.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (D + 2) tick();
    go = 2'b01;
    tick();
    go = 2'b00;
    tick();
    check("pre_reset_turn", 32'(turn), 32'd1);
    press_code(1'b1, 1'b0, 3'b111, 2'b01, 3'b111, "pre_reset");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset_data", 32'(data), 32'd0);
    check("mid_reset_turn", 32'(turn), 32'd0);
    check("mid_reset_color", 32'(color_out), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 2 * D; i++) begin
      tick();
      seen |= (data != 2'b00);
    end
    key_confirm_n = 1'b1;
    for (int i = 0; i < D + 4; i++) begin
      tick();
      seen |= (data != 2'b00);
    end
    check("mid_reset_no_code", 32'(seen), 32'd0);
    press_code(1'b1, 1'b0, 3'b100, 2'b01, 3'b100, "post_reset");
    release_code(2'b01, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
